// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: holds the architectural fetch PC, issues it over valid/ready,
// arbitrates trap/execute/decode redirects, and manages boot delay and halt/resume.
module fetch_pc_unit #(
  parameter int unsigned  XLEN       = 64,
  parameter logic [63:0]  RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int unsigned  INST_BYTES = 4,
  parameter int unsigned  EPOCH_W    = 2,
  parameter int unsigned  BOOT_DELAY = 1
) (
  input  logic               core_clk,
  input  logic               core_rst,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic               ex_redirect_valid,
  input  logic [XLEN-1:0]    ex_redirect_pc,
  input  logic               id_redirect_valid,
  input  logic [XLEN-1:0]    id_redirect_pc,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               resume,
  input  logic               pc_ready,
  output logic [XLEN-1:0]    pc,
  output logic               pc_valid,
  output logic [EPOCH_W-1:0] pc_epoch,
  output logic               flush_front,
  output logic               pc_misalign,
  output logic               halted
);

  localparam int unsigned BOOT_CW = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BOOT_CW-1:0]   boot_cnt_q, boot_cnt_d;
  logic [XLEN-1:0]      pc_d;
  logic [EPOCH_W-1:0]   epoch_d;
  logic                 flush_d;
  logic                 redirect;
  logic [XLEN-1:0]      redirect_target;
  logic                 fire;

  // Highest-priority redirect source wins; bit 0 of the target is always dropped
  always_comb begin
    redirect        = 1'b1;
    redirect_target = trap_pc;
    if (trap_valid) begin
      redirect_target = trap_pc;
    end else if (ex_redirect_valid) begin
      redirect_target = ex_redirect_pc;
    end else if (id_redirect_valid) begin
      redirect_target = id_redirect_pc;
    end else begin
      redirect = 1'b0;
    end
    redirect_target[0] = 1'b0;
  end

  assign fire = pc_valid & pc_ready & ~stall;

  // Next-state, next-PC and epoch/flush generation
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc;
    epoch_d    = pc_epoch;
    flush_d    = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + BOOT_CW'(1);
        if (boot_cnt_q == BOOT_CW'(BOOT_DELAY - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    // Redirects apply in RUN and HALT; sequential advance only while issuing
    if (state_q != ST_BOOT) begin
      if (redirect) begin
        pc_d    = redirect_target;
        epoch_d = pc_epoch + EPOCH_W'(1);
        flush_d = 1'b1;
      end else if (state_q == ST_RUN && fire) begin
        pc_d = pc + XLEN'(INST_BYTES);
      end
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= '0;
      pc          <= XLEN'(RESET_PC);
      pc_valid    <= 1'b0;
      pc_epoch    <= '0;
      flush_front <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pc          <= pc_d;
      pc_valid    <= (state_d == ST_RUN);
      pc_epoch    <= epoch_d;
      flush_front <= flush_d;
      halted      <= (state_d == ST_HALT);
    end
  end

  // Misalignment is only possible with 4-byte instructions
  generate
    if (INST_BYTES == 4) begin : g_misalign4
      assign pc_misalign = pc[1];
    end else begin : g_misalign2
      assign pc_misalign = 1'b0;
    end
  endgenerate

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Parametrised next-generation PC generator for the fetch front end. Holds the architectural fetch PC and issues it to the instruction fetch stage over a valid/ready handshake. Arbitrates three prioritised redirect sources (trap, execute-stage branch resolve, decode-stage jump). Provides a redirect epoch tag and a front-end flush pulse so downstream stages can drop stale instructions, plus boot-delay and halt/resume control.

Parameters:
XLEN, 64, PC width in bits.
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset (truncated to XLEN).
INST_BYTES, 4, sequential PC increment; legal values are 2 or 4.
EPOCH_W, 2, width of the redirect epoch counter.
BOOT_DELAY, 1, cycles spent in BOOT after reset release; must be at least 1.

Ports:
core_clk  in  1  clock
core_rst  in  1  asynchronous, active-high reset
trap_valid  in  1  trap/exception redirect request
trap_pc  in  XLEN  trap target
ex_redirect_valid  in  1  execute-stage branch/jalr redirect
ex_redirect_pc  in  XLEN  execute redirect target
id_redirect_valid  in  1  decode-stage jal redirect
id_redirect_pc  in  XLEN  decode redirect target
stall  in  1  back-pressure from downstream; blocks sequential advance only
halt_req  in  1  request to stop fetching
resume  in  1  leave HALT
pc_ready  in  1  fetch stage accepts pc this cycle
pc  out  XLEN  current fetch PC
pc_valid  out  1  pc is a valid fetch request
pc_epoch  out  EPOCH_W  epoch tag of the current pc
flush_front  out  1  one-cycle pulse after any accepted redirect
pc_misalign  out  1  pc is not INST_BYTES-aligned
halted  out  1  unit is in HALT

Behaviour:
- Reset, asynchronous on core_rst: pc=RESET_PC, pc_valid=0, pc_epoch=0, flush_front=0, halted=0, state=BOOT, boot counter=0.
- States: BOOT, RUN, HALT. All outputs are registered except pc_misalign.
- pc_valid = (state==RUN). halted = (state==HALT).
- BOOT:
  - Boot counter increments every cycle.
  - After BOOT_DELAY rising edges following reset release, state goes to RUN. With BOOT_DELAY=1, pc_valid is high in the 2nd cycle after release.
  - All redirects, halt_req and resume are ignored.
- fire = pc_valid & pc_ready & !stall.
- Next-PC priority, evaluated each cycle in RUN and HALT:
  1. trap_valid
  2. ex_redirect_valid
  3. id_redirect_valid
  4. fire (RUN only): pc <= pc + INST_BYTES, modulo 2^XLEN
  5. otherwise hold.
- Redirect (priorities 1-3):
  - pc <= target with bit 0 cleared.
  - pc_epoch <= pc_epoch+1, wrapping modulo 2^EPOCH_W.
  - flush_front=1 for exactly the next cycle.
  - Redirects are not gated by stall, pc_ready or pc_valid.
  - Simultaneous redirects: only the highest priority is applied, and epoch increments once.
- Handshake: while pc_valid & !pc_ready, pc and pc_epoch stay stable unless a redirect occurs. A redirect may change pc mid-handshake; the fetch stage discards it via flush_front/epoch.
- stall=1 with pc_ready=1 does not advance pc.
- halt_req in RUN: state goes to HALT next cycle, so pc_valid=0 and halted=1. A redirect in the same cycle still updates pc/epoch/flush_front. A fire in the same cycle still advances pc.
- HALT: pc_valid=0. Redirects are still applied, so the trap target is captured. halt_req is ignored. resume goes to RUN next cycle. A redirect and resume in the same cycle both take effect.
- pc_misalign (combinational): pc[1] when INST_BYTES==4; constant 0 when INST_BYTES==2.
- Reset asserted mid-operation: immediate return to reset values. Any pending flush_front is cancelled.

Test Plan:
- Reset release, BOOT_DELAY=1, pc_ready=1, stall=0 -> pc_valid rises the 2nd cycle after release with pc=0x80000000. Then pc=0x80000004, then 0x80000008 on successive cycles; epoch=0 and flush_front=0 throughout.
- pc_valid=1, pc_ready held 0 for 3 cycles, then 1 -> pc holds 0x80000008 for 3 cycles, then becomes 0x8000000C. stall=1 with pc_ready=1 -> pc holds.
- Same cycle: trap_valid (0x100), ex_redirect_valid (0x200), id_redirect_valid (0x300) -> next cycle pc=0x100, epoch 0->1, flush_front=1 for one cycle only.
- Four back-to-back ex redirects, EPOCH_W=2 -> epoch sequence 1,2,3,0. Target 0x80000013 yields pc=0x80000012 with pc_misalign=1.
- halt_req in RUN -> next cycle pc_valid=0, halted=1. trap_valid (0x200) while halted -> pc=0x200, epoch increments, pc_valid stays 0. resume -> pc_valid=1 with pc=0x200.
- pc=0xFFFF_FFFF_FFFF_FFFC, fire -> pc wraps to 0x0. Assert core_rst mid-redirect -> pc=RESET_PC, epoch=0, flush_front=0 immediately.
